// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the 9-bit
// accumulator core. Handshakes with a variable-latency data memory and
// keeps a saturating retired-instruction count.
module multicycle_control #(
  parameter int             IW          = 9,
  parameter int             OPW         = 3,
  parameter int             ALUW        = 3,
  parameter int             CNTW        = 16,
  parameter int             MEM_TIMEOUT = 15,
  parameter logic [IW-1:0]  HALT_INSTR  = 9'b111_0_11111
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [IW-1:0]   instr,
  input  logic            r0_nz,
  input  logic            mem_ready,
  output logic            ir_load,
  output logic            pc_en,
  output logic            pc_clear,
  output logic            branch_taken,
  output logic [ALUW-1:0] alu_op,
  output logic            alu_src,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            busy,
  output logic            done,
  output logic            mem_err,
  output logic [CNTW-1:0] retired,
  output logic [2:0]      state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6
  } state_t;

  // Timeout limit held as a 16-bit compare value; counter only runs in MEM.
  localparam int TLIM = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  state_t          state, nxt;
  logic [IW-1:0]   ir;
  logic [15:0]     tcnt;
  logic [OPW-1:0]  opc;
  logic            mode, is_ldm, restart, tout;

  assign opc     = ir[IW-1 -: OPW];
  assign mode    = ir[IW-OPW-1];
  // Only LDM and STR ever reach MEM, so "not LDM" there means STR.
  assign is_ldm  = (opc == OPW'(5)) && !mode;
  assign restart = ((state == S_IDLE) || (state == S_HALT)) && start;
  // Fires on the MEM_TIMEOUT-th MEM cycle that still lacks mem_ready.
  assign tout    = (MEM_TIMEOUT != 0) && (tcnt == 16'(TLIM)) && !mem_ready;
  assign state_o = state;

  // Next-state and control decode; Moore on state/IR except the memory
  // completion pulse and branch_taken following r0_nz.
  always_comb begin
    nxt          = state;
    ir_load      = 1'b0;
    pc_en        = 1'b0;
    pc_clear     = 1'b0;
    branch_taken = 1'b0;
    alu_op       = '0;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_to_reg   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          pc_clear = !reset;
          nxt      = S_FETCH;
        end
      end
      S_FETCH: begin
        busy    = 1'b1;
        ir_load = 1'b1;
        nxt     = S_DECODE;
      end
      S_DECODE: begin
        busy = 1'b1;
        nxt  = (ir == HALT_INSTR) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        busy = 1'b1;
        nxt  = S_WB;
        case (opc)
          OPW'(0): alu_op = ALUW'(0);
          OPW'(1): alu_op = ALUW'(1);
          OPW'(2): alu_op = ALUW'(2);
          OPW'(3): alu_op = ALUW'(3);
          OPW'(4): begin alu_op = ALUW'(4); alu_src = 1'b1; end
          OPW'(5): begin
            if (mode) alu_src = 1'b1;
            else      nxt     = S_MEM;
          end
          OPW'(6): nxt = S_MEM;
          OPW'(7): begin
            pc_en        = 1'b1;
            branch_taken = !mode || r0_nz;
            nxt          = S_FETCH;
          end
          default: begin
            // Wider opcode spaces: unknown opcodes retire as NOP.
            pc_en = 1'b1;
            nxt   = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        busy      = 1'b1;
        mem_read  = is_ldm;
        mem_write = !is_ldm;
        if (mem_ready) begin
          if (is_ldm) nxt = S_WB;
          else begin
            pc_en = 1'b1;
            nxt   = S_FETCH;
          end
        end else if (tout) begin
          nxt = S_HALT;
        end
      end
      S_WB: begin
        busy       = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = is_ldm;
        pc_en      = 1'b1;
        nxt        = S_FETCH;
      end
      S_HALT: begin
        done = 1'b1;
        if (start) begin
          pc_clear = !reset;
          nxt      = S_FETCH;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // Internal IR captures the ROM word at the end of FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 ir <= '0;
    else if (state == S_FETCH) ir <= instr;
  end

  // MEM wait counter: cleared on entry, counts cycles without mem_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                tcnt <= '0;
    else if (state != S_MEM && nxt == S_MEM)  tcnt <= '0;
    else if (state == S_MEM && !mem_ready)    tcnt <= tcnt + 16'd1;
  end

  // Retired count: one per pc_en pulse, saturating, cleared on (re)start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       retired <= '0;
    else if (restart)                retired <= '0;
    else if (pc_en && !(&retired))   retired <= retired + CNTW'(1);
  end

  // Sticky memory-timeout flag, cleared on (re)start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        mem_err <= 1'b0;
    else if (restart)                 mem_err <= 1'b0;
    else if (state == S_MEM && tout)  mem_err <= 1'b1;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with hand-computed expectations.
module tb_multicycle_control;

  logic        clk, reset, start, r0_nz, mem_ready;
  logic [8:0]  instr;
  logic        ir_load, pc_en, pc_clear, branch_taken, alu_src, reg_write;
  logic        mem_read, mem_write, mem_to_reg, busy, done, mem_err;
  logic [2:0]  alu_op, state_o;
  logic [15:0] retired;
  int          nerr = 0, nchk = 0, nrd;

  multicycle_control dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .r0_nz(r0_nz),
    .mem_ready(mem_ready), .ir_load(ir_load), .pc_en(pc_en),
    .pc_clear(pc_clear), .branch_taken(branch_taken), .alu_op(alu_op),
    .alu_src(alu_src), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .busy(busy),
    .done(done), .mem_err(mem_err), .retired(retired), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // FETCH then DECODE; returns one cycle into EXEC (or HALT).
  task automatic fetch_dec(input logic [8:0] ins);
    instr = ins; #1;
    chk("fetch_state", 32'(state_o), 1);
    chk("fetch_ir_load", 32'(ir_load), 1);
    tick();
    instr = 9'h0; #1;               // IR must already be latched internally
    chk("dec_state", 32'(state_o), 2);
    chk("dec_ir_load", 32'(ir_load), 0);
    chk("dec_pc_en", 32'(pc_en), 0);
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instr = '0; r0_nz = 1'b0; mem_ready = 1'b0;
    #12;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_outs", 32'({ir_load, pc_en, pc_clear, branch_taken, alu_op, alu_src,
        reg_write, mem_read, mem_write, mem_to_reg, busy, done, mem_err}), 0);
    chk("rst_retired", 32'(retired), 0);
    reset = 1'b0;

    // start from IDLE
    start = 1'b1; #1;
    chk("idle_pc_clear", 32'(pc_clear), 1);
    chk("idle_busy", 32'(busy), 0);
    tick(); start = 1'b0;

    // ADD: 4 cycles, retired -> 1
    fetch_dec(9'b001_010_011);
    chk("add_exec_state", 32'(state_o), 3);
    chk("add_alu_op", 32'(alu_op), 1);
    chk("add_alu_src", 32'(alu_src), 0);
    chk("add_exec_pc_en", 32'(pc_en), 0);
    tick();
    chk("add_wb_state", 32'(state_o), 5);
    chk("add_wb", 32'({reg_write, pc_en, mem_to_reg}), 32'b110);
    tick();
    chk("add_retired", 32'(retired), 1);
    chk("add_next_fetch", 32'(state_o), 1);

    // LDM with mem_ready on 4th MEM cycle: 8 cycles total
    fetch_dec(9'b101_0_00011);
    chk("ldm_exec_pc_en", 32'(pc_en), 0);
    tick();
    nrd = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ldm_wait_state", 32'(state_o), 4);
      chk("ldm_wait_pc_en", 32'(pc_en), 0);
      if (mem_read) nrd++;
      tick();
    end
    mem_ready = 1'b1; #1;
    if (mem_read) nrd++;
    chk("ldm_ready_pc_en", 32'(pc_en), 0);
    tick(); mem_ready = 1'b0; #1;
    chk("ldm_rd_cycles", 32'(nrd), 4);
    chk("ldm_wb_state", 32'(state_o), 5);
    chk("ldm_wb", 32'({reg_write, pc_en, mem_to_reg, mem_read}), 32'b1110);
    tick();
    chk("ldm_retired", 32'(retired), 2);

    // BNZ, r0_nz=0 then r0_nz toggled combinationally
    fetch_dec(9'b111_1_00101);
    r0_nz = 1'b0; #1;
    chk("bnz0_exec", 32'({state_o, pc_en, branch_taken}), 32'b011_1_0);
    r0_nz = 1'b1; #1;
    chk("bnz_comb_taken", 32'(branch_taken), 1);
    tick();
    chk("bnz_back_fetch", 32'(state_o), 1);
    chk("bnz_retired", 32'(retired), 3);
    fetch_dec(9'b111_1_00101);
    chk("bnz1_taken", 32'({pc_en, branch_taken}), 32'b11);
    tick();
    // Unconditional BR with r0_nz=0
    r0_nz = 1'b0;
    fetch_dec(9'b111_0_00001);
    chk("br_taken", 32'({pc_en, branch_taken}), 32'b11);
    tick();
    chk("br_retired", 32'(retired), 5);

    // STR timeout: 15 MEM cycles then HALT with mem_err
    fetch_dec(9'b110_0_00010);
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("str_to_mem", 32'({state_o, mem_write, mem_read, pc_en}), 32'b100_1_0_0);
      tick();
    end
    chk("to_state", 32'(state_o), 6);
    chk("to_flags", 32'({mem_err, done, busy}), 32'b110);
    chk("to_retired", 32'(retired), 5);
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    chk("halt_ignores_ready", 32'(state_o), 6);

    // Restart from HALT
    start = 1'b1; #1;
    chk("halt_pc_clear", 32'(pc_clear), 1);
    tick(); start = 1'b0;
    chk("restart_state", 32'(state_o), 1);
    chk("restart_clr", 32'({retired, mem_err}), 0);

    // LSR (start ignored while busy)
    fetch_dec(9'b100_001_001);
    start = 1'b1; #1;
    chk("lsr_exec", 32'({alu_op, alu_src, pc_clear}), 32'b100_1_0);
    tick(); start = 1'b0;
    chk("lsr_wb_state", 32'(state_o), 5);
    tick();
    // LDI
    fetch_dec(9'b101_1_00111);
    chk("ldi_exec", 32'({state_o, alu_op, alu_src}), 32'b011_000_1);
    tick();
    chk("ldi_wb", 32'({state_o, mem_to_reg, reg_write}), 32'b101_0_1);
    tick();
    // STR with zero wait
    fetch_dec(9'b110_0_00001);
    tick();
    mem_ready = 1'b1; #1;
    chk("str_mem", 32'({state_o, mem_write, pc_en}), 32'b100_1_1);
    tick(); mem_ready = 1'b0;
    chk("str_back_fetch", 32'(state_o), 1);
    // HALT instruction
    fetch_dec(9'b111_0_11111);
    chk("halt_state", 32'(state_o), 6);
    chk("halt_flags", 32'({done, busy, pc_en}), 32'b100);
    chk("halt_retired", 32'(retired), 3);
    start = 1'b1; #1;
    chk("halt2_pc_clear", 32'(pc_clear), 1);
    tick(); start = 1'b0;
    chk("halt2_restart", 32'({state_o, retired}), 32'({3'd1, 16'd0}));

    // Reset in the middle of a store
    fetch_dec(9'b001_000_001);
    tick(); tick();
    fetch_dec(9'b110_0_00011);
    tick(); #1;
    chk("pre_rst_mem_write", 32'(mem_write), 1);
    reset = 1'b1; #1;
    chk("midrst", 32'({state_o, mem_write, pc_en, retired}), 0);
    tick(); reset = 1'b0; tick();
    chk("post_rst_idle", 32'({state_o, pc_en}), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parameterised multi-cycle control unit for the 9-bit accumulator-style core; the sequential successor of the single-cycle opcode decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and handshakes with a variable-latency data memory. It drives the datapath enables (IR load, PC advance, register/memory writes, ALU controls) and keeps a retired-instruction count. It sits between the PC/instruction ROM, the register file/ALU and the data-memory port.

## Interface
- IW, 9: instruction width.
- OPW, 3: opcode width; opcode = instr[IW-1:IW-OPW], mode bit = instr[IW-OPW-1].
- ALUW, 3: ALU op width.
- CNTW, 16: retired-count width.
- MEM_TIMEOUT, 15: maximum MEM cycles without mem_ready; 0 disables the timeout.
- HALT_INSTR, 9'b111_0_11111: instruction treated as halt.
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  begin/restart execution; sampled only in IDLE or HALT.
- instr  input  IW  instruction-ROM output, valid during FETCH.
- r0_nz  input  1  r0 != 0 flag from the register file.
- mem_ready  input  1  data-memory access complete.
- ir_load  output  1  load external IR.
- pc_en  output  1  advance/update PC (one-cycle pulse per retire).
- pc_clear  output  1  reset PC to 0 on (re)start.
- branch_taken  output  1  PC takes branch target (valid with pc_en).
- alu_op  output  ALUW  ALU operation.
- alu_src  output  1  ALU operand B = immediate.
- reg_write  output  1  register-file write enable.
- mem_read  output  1  data-memory read request.
- mem_write  output  1  data-memory write request.
- mem_to_reg  output  1  write-back source = memory.
- busy  output  1  executing (not IDLE/HALT).
- done  output  1  in HALT.
- mem_err  output  1  sticky memory-timeout flag.
- retired  output  CNTW  retired-instruction count, saturating.
- state_o  output  3  current state.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Reset: state IDLE; all outputs 0; internal IR, timeout counter, retired and mem_err cleared. Reset mid-instruction aborts without any further write pulse.
- IDLE: start=1 -> FETCH with pc_clear=1 in the IDLE cycle; retired and mem_err cleared.
- FETCH: ir_load=1; the internal IR latches instr at the end of the cycle; -> DECODE.
- DECODE: no enables asserted. IR==HALT_INSTR -> HALT, otherwise -> EXEC.
- EXEC (alu_op and alu_src driven from IR):
  - MOV/ADD/AND/XOR: alu_op = 000/001/010/011, alu_src=0; -> WB.
  - LSR: alu_op=100, alu_src=1; -> WB.
  - LDI (101, mode=1): alu_src=1; -> WB.
  - LDM (101, mode=0): -> MEM.
  - STR (110): -> MEM.
  - BR (111): pc_en=1; branch_taken = (mode==0) | r0_nz; -> FETCH.
  - Opcode values >7 (OPW>3): NOP, pc_en=1, branch_taken=0; -> FETCH.
- MEM: mem_read=1 (LDM) or mem_write=1 (STR), held until mem_ready.
  - On mem_ready: LDM -> WB; STR -> FETCH with pc_en=1.
  - Timeout counter increments on each MEM cycle with mem_ready=0. If mem_ready is still low on the MEM_TIMEOUT-th MEM cycle: -> HALT, mem_err=1, no pc_en.
- WB: reg_write=1; mem_to_reg=1 for LDM; pc_en=1; -> FETCH.
- HALT: done=1, busy=0. start=1 -> FETCH with pc_clear=1; retired and mem_err cleared.
- Every pc_en pulse increments retired by 1, saturating at 2^CNTW-1.

## Timing
- Control outputs are Moore outputs of state plus latched IR. branch_taken is combinational on r0_nz during EXEC.
- Cycles per instruction: ALU/LSR/LDI = 4; BR = 3; LDM = 5 + wait; STR = 4 + wait, where wait = MEM cycles before mem_ready. mem_ready on the first MEM cycle gives wait=0.
- start is ignored in FETCH..WB. mem_ready is ignored outside MEM.
- The timeout counter clears on every entry to MEM.

## Test plan
- Reset mid-MEM with mem_write=1 -> next sample: state_o=0, mem_write=0, retired=0, no pc_en.
- start, then instr=9'b001_010_011 (ADD) -> ir_load at cycle 1; alu_op=001 at cycle 3; reg_write+pc_en at cycle 4; retired=1.
- LDM with mem_ready after 3 MEM cycles -> mem_read high for 4 cycles; WB with mem_to_reg=1; total 8 cycles.
- BNZ (111_1_00101): r0_nz=0 -> pc_en=1, branch_taken=0; r0_nz=1 -> branch_taken=1; 3 cycles each.
- STR with mem_ready never asserted, MEM_TIMEOUT=15 -> HALT after 15 MEM cycles, mem_err=1, done=1, retired unchanged.
- HALT_INSTR after 3 instructions -> done=1 with retired=3; start -> pc_clear pulse, retired=0, FETCH.
